// File: rtl/parking_gate_ctrl.sv
// parking_gate_ctrl: car-park entry gate controller. A password-gated FSM with
// occupancy counting, a capacity limit, password-entry timeout and blinking
// status lamps. Defining PARK_LOCKOUT_EN builds the attempt lockout (LOCKED).
module parking_gate_ctrl #(
  parameter int DIGITS    = 4,
  parameter int DIGIT_W   = 4,
  parameter logic [DIGITS*DIGIT_W-1:0] PASSKEY = 16'h1234,
  parameter int CAPACITY  = 15,
  parameter int CNT_W     = 4,
  parameter int WAIT_CYC  = 8,
  parameter int BLINK_DIV = 2,
  parameter int MAX_TRIES = 3,
  parameter int LOCK_CYC  = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      fs,
  input  logic                      bs,
  input  logic [DIGITS*DIGIT_W-1:0] pass_in,
  input  logic                      pass_valid,
  input  logic                      exit_evt,
  output logic                      g_led,
  output logic                      r_led,
  output logic [CNT_W-1:0]          car_count,
  output logic                      full,
  output logic                      lockout
);

  // One timer is shared by the entry timeout, the fs-low timeout and the lockout.
  localparam int TMR_MAX = (LOCK_CYC > WAIT_CYC) ? LOCK_CYC : WAIT_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int TRY_W   = $clog2(MAX_TRIES + 1);
  localparam int BLK_W   = $clog2(BLINK_DIV + 1);
  localparam logic [TMR_W-1:0] WAIT_LAST = TMR_W'(WAIT_CYC - 1);
  localparam logic [TRY_W-1:0] TRY_MAX   = TRY_W'(MAX_TRIES);
  localparam logic [BLK_W-1:0] BLK_LAST  = BLK_W'(BLINK_DIV - 1);
  localparam logic [CNT_W-1:0] CAP       = CNT_W'(CAPACITY);
`ifdef PARK_LOCKOUT_EN
  localparam logic [TMR_W-1:0] LOCK_LAST = TMR_W'(LOCK_CYC - 1);
`endif

  typedef enum logic [2:0] {
    IDLE, WAIT_PASS, DENIED, ACCEPT, STOP
`ifdef PARK_LOCKOUT_EN
    , LOCKED
`endif
  } state_t;

  state_t             state, state_next;
  logic [TMR_W-1:0]   tmr, tmr_next;
  logic [TRY_W-1:0]   tries, tries_next, tries_sat;
  logic [BLK_W-1:0]   bcnt, bcnt_next;
  logic               blink, blink_next;
  logic               bs_prev;
  logic [CNT_W-1:0]   count_next;
  logic               full_next, g_next, r_next;
  logic               match, miss, bs_rise, inc;

  assign match     = pass_valid && (pass_in == PASSKEY);
  assign miss      = pass_valid && (pass_in != PASSKEY);
  assign bs_rise   = bs && !bs_prev;
  assign tries_sat = (tries == TRY_MAX) ? tries : tries + 1'b1;

  // Next-state, timer, attempt count, occupancy and lamp values.
  always_comb begin
    state_next = state;
    tmr_next   = tmr;
    tries_next = tries;
    inc        = 1'b0;
    case (state)
      IDLE: begin
        if (fs && !full) begin
          state_next = WAIT_PASS;
          tmr_next   = '0;
        end
      end
      WAIT_PASS: begin
        if (match) begin
          state_next = ACCEPT;
        end else if (miss) begin
          state_next = DENIED;
          tries_next = TRY_W'(1);
          tmr_next   = '0;
        end else if (tmr == WAIT_LAST) begin
          state_next = IDLE;
        end else begin
          tmr_next = tmr + 1'b1;
        end
      end
      DENIED: begin
        if (match) begin
          state_next = ACCEPT;
        end else begin
          if (miss) tries_next = tries_sat;
          // Timer counts consecutive cycles with the front sensor clear.
          tmr_next = fs ? '0 : tmr + 1'b1;
          if (!fs && tmr == WAIT_LAST) state_next = IDLE;
`ifdef PARK_LOCKOUT_EN
          if (miss && tries_sat == TRY_MAX) begin
            state_next = LOCKED;
            tmr_next   = '0;
          end
`endif
        end
      end
      ACCEPT: begin
        if (bs_rise) begin
          if (fs) begin
            state_next = STOP;
          end else begin
            state_next = IDLE;
            inc        = 1'b1;
          end
        end
      end
      STOP: begin
        if (match) begin
          state_next = ACCEPT;
        end else if (miss) begin
          state_next = DENIED;
          tries_next = TRY_W'(1);
          tmr_next   = '0;
        end
      end
`ifdef PARK_LOCKOUT_EN
      LOCKED: begin
        if (tmr == LOCK_LAST) state_next = IDLE;
        else tmr_next = tmr + 1'b1;
      end
`endif
      default: state_next = IDLE;
    endcase
    if (state_next == IDLE || state_next == ACCEPT) tries_next = '0;

    // An entry and an exit in the same cycle cancel out.
    count_next = car_count;
    if (inc && !exit_evt) begin
      count_next = (car_count == CAP) ? car_count : car_count + 1'b1;
    end else if (!inc && exit_evt) begin
      count_next = (car_count == '0) ? car_count : car_count - 1'b1;
    end
    full_next = (count_next == CAP);

    // Blink phase restarts lit on every state change.
    if (state_next != state) begin
      blink_next = 1'b1;
      bcnt_next  = '0;
    end else if (bcnt == BLK_LAST) begin
      blink_next = !blink;
      bcnt_next  = '0;
    end else begin
      blink_next = blink;
      bcnt_next  = bcnt + 1'b1;
    end

    g_next = 1'b0;
    r_next = 1'b0;
    case (state_next)
      IDLE:      r_next = full_next;
      WAIT_PASS: r_next = 1'b1;
      DENIED:    r_next = blink_next;
      ACCEPT:    g_next = blink_next;
      STOP:      r_next = blink_next;
`ifdef PARK_LOCKOUT_EN
      LOCKED:    r_next = 1'b1;
`endif
      default:   r_next = 1'b0;
    endcase
  end

  // State and registered outputs; reset drops occupancy and aborts any state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      tmr       <= '0;
      tries     <= '0;
      bcnt      <= '0;
      blink     <= 1'b0;
      bs_prev   <= 1'b1;
      car_count <= '0;
      full      <= 1'b0;
      g_led     <= 1'b0;
      r_led     <= 1'b0;
    end else begin
      state     <= state_next;
      tmr       <= tmr_next;
      tries     <= tries_next;
      bcnt      <= bcnt_next;
      blink     <= blink_next;
      bs_prev   <= bs;
      car_count <= count_next;
      full      <= full_next;
      g_led     <= g_next;
      r_led     <= r_next;
    end
  end

`ifdef PARK_LOCKOUT_EN
  // Lockout indicator follows the LOCKED state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) lockout <= 1'b0;
    else       lockout <= (state_next == LOCKED);
  end
`else
  assign lockout = 1'b0;
`endif

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// tb_parking_gate_ctrl: directed table, hand-written corner sequences and a
// randomized run, all compared against a behavioural gate model.
module tb_parking_gate_ctrl;
  localparam int CAPACITY  = 15;
  localparam int WAIT_CYC  = 8;
  localparam int BLINK_DIV = 2;
  localparam int MAX_TRIES = 3;
  localparam int LOCK_CYC  = 16;
  localparam logic [15:0] KEY = 16'h1234;
  localparam logic [15:0] BAD = 16'h1111;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic fs = 1'b0, bs = 1'b0, pass_valid = 1'b0, exit_evt = 1'b0;
  logic [15:0] pass_in = '0;
  logic g_led, r_led, full, lockout;
  logic [3:0] car_count;

  int checks = 0;
  int errors = 0;

  parking_gate_ctrl #(
    .DIGITS(4), .DIGIT_W(4), .PASSKEY(KEY), .CAPACITY(CAPACITY), .CNT_W(4),
    .WAIT_CYC(WAIT_CYC), .BLINK_DIV(BLINK_DIV), .MAX_TRIES(MAX_TRIES), .LOCK_CYC(LOCK_CYC)
  ) dut (
    .clk(clk), .reset(reset), .fs(fs), .bs(bs), .pass_in(pass_in),
    .pass_valid(pass_valid), .exit_evt(exit_evt), .g_led(g_led), .r_led(r_led),
    .car_count(car_count), .full(full), .lockout(lockout)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  typedef enum int {M_IDLE, M_WAIT, M_DEN, M_ACC, M_STOP, M_LOCK} mst_t;
  mst_t m_st;
  int   m_age, m_fslow, m_tries, m_count;
  bit   m_bs_prev, m_g, m_r, m_full, m_lock;

  task automatic model_reset();
    m_st = M_IDLE; m_age = 0; m_fslow = 0; m_tries = 0; m_count = 0;
    m_bs_prev = 1'b1; m_g = 0; m_r = 0; m_full = 0; m_lock = 0;
  endtask

  task automatic model_step(input bit f, input bit b, input bit pv, input logic [15:0] pi, input bit ex);
    bit match, miss, rise, blink;
    int inc, n;
    mst_t ns;
    match = pv && (pi == KEY);
    miss  = pv && (pi != KEY);
    rise  = b && !m_bs_prev;
    inc   = 0;
    ns    = m_st;
    case (m_st)
      M_IDLE: if (f && m_count != CAPACITY) ns = M_WAIT;
      M_WAIT: begin
        if (match) ns = M_ACC;
        else if (miss) begin ns = M_DEN; m_tries = 1; end
        else if (m_age + 1 >= WAIT_CYC) ns = M_IDLE;
      end
      M_DEN: begin
        if (match) ns = M_ACC;
        else begin
          if (miss && m_tries < MAX_TRIES) m_tries++;
          m_fslow = f ? 0 : m_fslow + 1;
          if (m_fslow >= WAIT_CYC) ns = M_IDLE;
`ifdef PARK_LOCKOUT_EN
          if (miss && m_tries >= MAX_TRIES) ns = M_LOCK;
`endif
        end
      end
      M_ACC: if (rise) begin
        if (f) ns = M_STOP;
        else begin ns = M_IDLE; inc = 1; end
      end
      M_STOP: begin
        if (match) ns = M_ACC;
        else if (miss) begin ns = M_DEN; m_tries = 1; end
      end
      M_LOCK: if (m_age + 1 >= LOCK_CYC) ns = M_IDLE;
      default: ns = M_IDLE;
    endcase
    n = m_count + inc - int'(ex);
    if (n < 0) n = 0;
    if (n > CAPACITY) n = CAPACITY;
    m_count = n;
    if (ns != m_st) begin m_age = 0; m_fslow = 0; end
    else m_age++;
    if (ns == M_IDLE || ns == M_ACC) m_tries = 0;
    m_st = ns;
    m_bs_prev = b;
    blink  = ((m_age / BLINK_DIV) % 2) == 0;
    m_full = (m_count == CAPACITY);
    m_g    = (m_st == M_ACC) && blink;
    m_r    = (m_st == M_IDLE) ? m_full :
             (m_st == M_WAIT || m_st == M_LOCK) ? 1'b1 :
             (m_st == M_DEN || m_st == M_STOP) ? blink : 1'b0;
    m_lock = (m_st == M_LOCK);
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic compare_model();
    chk("model g_led", int'(g_led), int'(m_g));
    chk("model r_led", int'(r_led), int'(m_r));
    chk("model car_count", int'(car_count), m_count);
    chk("model full", int'(full), int'(m_full));
    chk("model lockout", int'(lockout), int'(m_lock));
  endtask

  task automatic apply(input bit f, input bit b, input bit pv, input logic [15:0] pi, input bit ex);
    fs = f; bs = b; pass_valid = pv; pass_in = pi; exit_evt = ex;
    @(posedge clk);
    model_step(f, b, pv, pi, ex);
    #1;
    compare_model();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    model_reset();
    #1;
    chk("reset g_led", int'(g_led), 0);
    chk("reset r_led", int'(r_led), 0);
    chk("reset car_count", int'(car_count), 0);
    chk("reset full", int'(full), 0);
    chk("reset lockout", int'(lockout), 0);
    reset = 1'b0;
  endtask

  task automatic add_car();
    apply(1, 0, 0, 16'h0, 0);
    apply(0, 0, 1, KEY, 0);
    apply(0, 1, 0, 16'h0, 0);
    apply(0, 0, 0, 16'h0, 0);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit f, b, pv, ex;
    logic [15:0] pi;
    bit g, r;
    int cnt;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(bit f, bit b, bit pv, logic [15:0] pi, bit ex, bit g, bit r, int cnt);
    vec_t v;
    v.f = f; v.b = b; v.pv = pv; v.pi = pi; v.ex = ex; v.g = g; v.r = r; v.cnt = cnt;
    return v;
  endfunction

  initial begin
    int base;
    bit cur_bs;

    // Entry with match, blinking green, car passes.
    tbl.push_back(mk(1, 0, 0, 0,   0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0,   0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 1, KEY, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,   0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,   0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,   0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,   0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0,   0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0,   0, 0, 0, 1));
    // Timeout: WAIT_PASS held for WAIT_CYC cycles with red lit.
    tbl.push_back(mk(1, 0, 0, 0,   0, 0, 1, 1));
    for (int i = 0; i < WAIT_CYC - 1; i++) tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0,   0, 0, 0, 1));
    // Tailgater: bs rises with fs high, red blinks in STOP, match resumes.
    tbl.push_back(mk(1, 0, 0, 0,   0, 0, 1, 1));
    tbl.push_back(mk(1, 0, 1, KEY, 0, 1, 0, 1));
    tbl.push_back(mk(1, 1, 0, 0,   0, 0, 1, 1));
    tbl.push_back(mk(1, 0, 0, 0,   0, 0, 1, 1));
    tbl.push_back(mk(1, 0, 0, 0,   0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0,   0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 1, KEY, 0, 1, 0, 1));
    tbl.push_back(mk(0, 1, 0, 0,   0, 0, 0, 2));
    tbl.push_back(mk(0, 0, 0, 0,   0, 0, 0, 2));

    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].f, tbl[i].b, tbl[i].pv, tbl[i].pi, tbl[i].ex);
      $display("vec %0d fs=%0b bs=%0b pv=%0b pin=%h ex=%0b -> g=%0b r=%0b cnt=%0d",
               i, tbl[i].f, tbl[i].b, tbl[i].pv, tbl[i].pi, tbl[i].ex, g_led, r_led, car_count);
      chk("table g_led", int'(g_led), int'(tbl[i].g));
      chk("table r_led", int'(r_led), int'(tbl[i].r));
      chk("table car_count", int'(car_count), tbl[i].cnt);
    end

    // Three wrong attempts.
    apply(1, 0, 0, 0, 0);
    apply(1, 0, 1, BAD, 0);
    chk("denied r_led", int'(r_led), 1);
    apply(1, 0, 1, BAD, 0);
    apply(0, 0, 1, BAD, 0);
`ifdef PARK_LOCKOUT_EN
    chk("lock enter", int'(lockout), 1);
    for (int i = 0; i < LOCK_CYC - 1; i++) begin
      apply(0, 0, 1, KEY, 0);
      chk("lock held", int'(lockout), 1);
      chk("lock g_led", int'(g_led), 0);
    end
    apply(0, 0, 0, 0, 0);
    chk("lock release", int'(lockout), 0);
    chk("lock idle r_led", int'(r_led), 0);
    base = 2;
`else
    chk("no lockout", int'(lockout), 0);
    chk("denied blink r_led", int'(r_led), 0);
    apply(0, 0, 1, KEY, 0);
    chk("fourth match g_led", int'(g_led), 1);
    apply(0, 1, 0, 0, 0);
    apply(0, 0, 0, 0, 0);
    base = 3;
`endif
    chk("count after tries", int'(car_count), base);

    // Fill to capacity.
    for (int k = base + 1; k <= CAPACITY; k++) begin
      add_car();
      chk("fill count", int'(car_count), k);
    end
    chk("full flag", int'(full), 1);
    chk("full r_led", int'(r_led), 1);
    apply(1, 0, 0, 0, 0);
    apply(0, 0, 1, KEY, 0);
    chk("full ignores fs", int'(g_led), 0);
    apply(0, 0, 0, 0, 1);
    chk("exit count", int'(car_count), CAPACITY - 1);
    chk("exit full", int'(full), 0);
    chk("exit r_led", int'(r_led), 0);
    for (int k = CAPACITY - 2; k >= 0; k--) apply(0, 0, 0, 0, 1);
    chk("drain count", int'(car_count), 0);
    apply(0, 0, 0, 0, 1);
    chk("exit at zero", int'(car_count), 0);

    // Entry and exit in the same cycle at count 3.
    for (int k = 0; k < 3; k++) add_car();
    apply(1, 0, 0, 0, 0);
    apply(0, 0, 1, KEY, 0);
    apply(0, 1, 0, 0, 1);
    chk("same-cycle count", int'(car_count), 3);
    apply(0, 0, 0, 0, 0);

    // Reset while in ACCEPT with five cars.
    add_car();
    add_car();
    apply(1, 0, 0, 0, 0);
    apply(0, 0, 1, KEY, 0);
    chk("pre-reset count", int'(car_count), 5);
    chk("pre-reset g_led", int'(g_led), 1);
    do_reset();

    // Randomized run against the model.
    cur_bs = 1'b0;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
      end else begin
        if ($urandom_range(0, 3) == 0) cur_bs = !cur_bs;
        apply(bit'($urandom_range(0, 1)), cur_bs,
              bit'($urandom_range(0, 4) == 0),
              ($urandom_range(0, 1) == 1) ? KEY : 16'($urandom),
              bit'($urandom_range(0, 15) == 0));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
